muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RISC-V M-extension multiply/divide unit.
//   Multiplies take one product cycle. Divides use a restoring shift-subtract
//   divider on operand magnitudes, one quotient bit per cycle. Divide-by-zero
//   and signed overflow skip the iterations and complete straight away.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   request a new operation this cycle
//   alu_ctrl  in   [ALUCTR_WIDTH] operation code from the ALU decoder
//   op_a      in   [DATA_WIDTH] rs1 operand / dividend
//   op_b      in   [DATA_WIDTH] rs2 operand / divisor
//   flush     in   abort any in-flight operation
//   busy      out  high while multiplying or dividing
//   done      out  one-cycle completion pulse, result valid this cycle
//   result    out  [DATA_WIDTH] registered result, held until next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALUCTR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [ALUCTR_WIDTH-1:0] OP_MUL    = ALUCTR_WIDTH'(10);
  localparam logic [ALUCTR_WIDTH-1:0] OP_MULH   = ALUCTR_WIDTH'(11);
  localparam logic [ALUCTR_WIDTH-1:0] OP_MULHSU = ALUCTR_WIDTH'(12);
  localparam logic [ALUCTR_WIDTH-1:0] OP_MULHU  = ALUCTR_WIDTH'(13);
  localparam logic [ALUCTR_WIDTH-1:0] OP_DIV    = ALUCTR_WIDTH'(14);
  localparam logic [ALUCTR_WIDTH-1:0] OP_DIVU   = ALUCTR_WIDTH'(15);
  localparam logic [ALUCTR_WIDTH-1:0] OP_REM    = ALUCTR_WIDTH'(16);
  localparam logic [ALUCTR_WIDTH-1:0] OP_REMU   = ALUCTR_WIDTH'(17);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [ALUCTR_WIDTH-1:0] ctrl_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [DATA_WIDTH-1:0]   rem_reg, quot_reg, dvsr_reg;
  logic [DATA_WIDTH-1:0]   result_reg;

  // ---------------------------------------------------------------------------
  // Decode of the incoming request
  // ---------------------------------------------------------------------------
  logic                  in_is_mul, in_is_div, in_div_signed, in_is_rem;
  logic                  in_div_zero, in_overflow, in_special;
  logic                  can_accept, accept;
  logic [DATA_WIDTH-1:0] in_abs_a, in_abs_b, special_result;

  always_comb begin
    in_is_mul     = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MULH) ||
                    (alu_ctrl == OP_MULHSU) || (alu_ctrl == OP_MULHU);
    in_is_div     = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU) ||
                    (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
    in_div_signed = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
    in_is_rem     = (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
    in_div_zero   = (op_b == '0);
    in_overflow   = in_div_signed && (op_a == MIN_INT) && (op_b == '1);
    in_special    = in_is_div && (in_div_zero || in_overflow);

    can_accept = (state_reg == S_IDLE) || (state_reg == S_DONE);
    accept     = start && !flush && can_accept && (in_is_mul || in_is_div);

    in_abs_a = (in_div_signed && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
    in_abs_b = (in_div_signed && op_b[DATA_WIDTH-1]) ? -op_b : op_b;

    // Divide-by-zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = MIN_INT (equal to op_a), remainder 0.
    if (in_div_zero)
      special_result = in_is_rem ? op_a : '1;
    else
      special_result = in_is_rem ? '0 : op_a;
  end

  // ---------------------------------------------------------------------------
  // Multiply datapath: operands sign- or zero-extended to 2W bits; the low
  // 2W bits of that product are correct for every signedness mix.
  // ---------------------------------------------------------------------------
  logic                    mul_a_signed, mul_b_signed;
  logic [2*DATA_WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic [DATA_WIDTH-1:0]   mul_result;

  always_comb begin
    mul_a_signed = (ctrl_reg == OP_MULH) || (ctrl_reg == OP_MULHSU);
    mul_b_signed = (ctrl_reg == OP_MULH);
    mul_a_ext    = {{DATA_WIDTH{mul_a_signed & a_reg[DATA_WIDTH-1]}}, a_reg};
    mul_b_ext    = {{DATA_WIDTH{mul_b_signed & b_reg[DATA_WIDTH-1]}}, b_reg};
    product      = mul_a_ext * mul_b_ext;
    mul_result   = (ctrl_reg == OP_MUL) ? product[DATA_WIDTH-1:0]
                                        : product[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Divide datapath: one restoring step per cycle. quot_reg starts as the
  // dividend magnitude and is shifted out MSB-first into the partial
  // remainder while quotient bits shift in at the bottom.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;
  logic [DATA_WIDTH-1:0] step_rem, step_quot;
  logic                  div_signed, div_is_rem, neg_quot, neg_rem;
  logic [DATA_WIDTH-1:0] div_result;

  always_comb begin
    rem_shift = {rem_reg, quot_reg[DATA_WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvsr_reg};
    // Borrow out of the subtract means the divisor did not fit: restore.
    step_rem  = rem_diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0]
                                     : rem_diff[DATA_WIDTH-1:0];
    step_quot = {quot_reg[DATA_WIDTH-2:0], ~rem_diff[DATA_WIDTH]};

    div_signed = (ctrl_reg == OP_DIV) || (ctrl_reg == OP_REM);
    div_is_rem = (ctrl_reg == OP_REM) || (ctrl_reg == OP_REMU);
    neg_quot   = div_signed && (a_reg[DATA_WIDTH-1] ^ b_reg[DATA_WIDTH-1]);
    neg_rem    = div_signed && a_reg[DATA_WIDTH-1];
    if (div_is_rem)
      div_result = neg_rem ? -step_rem : step_rem;
    else
      div_result = neg_quot ? -step_quot : step_quot;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (flush overrides everything except reset)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (in_is_mul)       state_next = S_MUL;
            else if (in_special) state_next = S_DONE;
            else                 state_next = S_DIV;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_MUL:   state_next = S_DONE;
        S_DIV:   if (cnt_reg == CNT_LAST) state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_reg == S_MUL) || (state_reg == S_DIV);
    done = (state_reg == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. result_reg only moves on an edge that enters DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      dvsr_reg   <= '0;
      result_reg <= '0;
    end else if (accept) begin
      ctrl_reg <= alu_ctrl;
      a_reg    <= op_a;
      b_reg    <= op_b;
      cnt_reg  <= '0;
      rem_reg  <= '0;
      quot_reg <= in_abs_a;
      dvsr_reg <= in_abs_b;
      if (in_special)
        result_reg <= special_result;
    end else if (!flush) begin
      if (state_reg == S_MUL) begin
        result_reg <= mul_result;
      end else if (state_reg == S_DIV) begin
        rem_reg  <= step_rem;
        quot_reg <= step_quot;
        cnt_reg  <= cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST)
          result_reg <= div_result;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  localparam logic [4:0] C_MUL = 5'b01010, C_MULH = 5'b01011, C_MULHSU = 5'b01100,
                         C_MULHU = 5'b01101, C_DIV = 5'b01110, C_DIVU = 5'b01111,
                         C_REM = 5'b10000, C_REMU = 5'b10001;

  muldiv_unit #(.DATA_WIDTH(32), .ALUCTR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation (called #1 after an edge) and wait for done.
  // lat counts edges from the start cycle to the cycle where done is seen.
  task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bsy_cnt, output logic [31:0] res);
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bsy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) bsy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    int lat, bsy;
    logic [31:0] res;
    int seen_done;

    vecs[0]  = '{C_MUL,    32'd6,        32'd7,        32'd42,       2,  1};
    vecs[1]  = '{C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2,  1};
    vecs[2]  = '{C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  1};
    vecs[3]  = '{C_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2,  1};
    vecs[4]  = '{C_MUL,    32'h12345678, 32'h10,       32'h23456780, 2,  1};
    vecs[5]  = '{C_MULHU,  32'h80000000, 32'd4,        32'h00000002, 2,  1};
    vecs[6]  = '{C_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, 2,  1};
    vecs[7]  = '{C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 32};
    vecs[8]  = '{C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 32};
    vecs[9]  = '{C_DIVU,   32'd100,      32'd7,        32'd14,       33, 32};
    vecs[10] = '{C_REMU,   32'd100,      32'd7,        32'd2,        33, 32};
    vecs[11] = '{C_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 32};
    vecs[12] = '{C_DIV,    32'd100,      32'hFFFFFFFD, 32'hFFFFFFDF, 33, 32};
    vecs[13] = '{C_REM,    32'd100,      32'hFFFFFFFD, 32'd1,        33, 32};
    vecs[14] = '{C_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1,  0};
    vecs[15] = '{C_REMU,   32'd100,      32'd0,        32'd100,      1,  0};
    vecs[16] = '{C_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  0};
    vecs[17] = '{C_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  0};
    vecs[18] = '{C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
    vecs[19] = '{C_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0};
    vecs[20] = '{C_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 32};
    vecs[21] = '{C_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 32};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    $display("[TB] reset: busy=%0b done=%0b result=0x%08h", busy, done, result);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-M codes are ignored
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; alu_ctrl = (i == 0) ? 5'b00000 : 5'b10010; op_a = 32'd3; op_b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("nonm%0d_busy", i), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("nonm%0d_done", i), {31'd0, done}, 32'd0);
      $display("[TB] non-M code %b: busy=%0b done=%0b", alu_ctrl, busy, done);
    end

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, bsy, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busycycles", i), bsy, vecs[i].bsy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      $display("[TB] vec %0d ctrl=%b a=0x%08h b=0x%08h -> result=0x%08h lat=%0d busy=%0d",
               i, vecs[i].ctrl, vecs[i].a, vecs[i].b, res, lat, bsy);
    end

    // Back-to-back: new start accepted in the DONE cycle
    run_op(C_MUL, 32'd3, 32'd4, lat, bsy, res);
    check("b2b_first_result", res, 32'd12);
    run_op(C_MUL, 32'd5, 32'd6, lat, bsy, res);
    check("b2b_second_result", res, 32'd30);
    check("b2b_second_latency", lat, 32'd2);
    $display("[TB] back-to-back MUL: result=0x%08h lat=%0d", res, lat);

    // Start while busy is ignored (DIVU 100/7, MUL pulsed at cycle 5)
    start = 1'b1; alu_ctrl = C_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    start = 1'b1; alu_ctrl = C_MUL; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    check("busy_start_latency", lat, 32'd33);
    check("busy_start_result", result, 32'd14);
    $display("[TB] start during DIVU: result=0x%08h lat=%0d", result, lat);
    @(posedge clk); #1;

    // Start during a signed-overflow-free DIV is ignored too
    start = 1'b1; alu_ctrl = C_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    start = 1'b1; alu_ctrl = C_DIV; op_a = 32'h80000000; op_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    check("div_start_ignored_busy", {31'd0, busy}, 32'd1);
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    check("div_start_ignored_latency", lat, 32'd33);
    check("div_start_ignored_result", result, 32'hFFFFFFFD);
    $display("[TB] start during DIV: result=0x%08h lat=%0d", result, lat);
    @(posedge clk); #1;

    // Flush at cycle 10 of a DIVU, with a competing start
    run_op(C_MUL, 32'd3, 32'd4, lat, bsy, res);
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = C_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b1; alu_ctrl = C_MUL; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen_done++;
      @(posedge clk); #1;
    end
    check("flush_no_activity", seen_done, 32'd0);
    check("flush_result_held", result, 32'd12);
    $display("[TB] flush DIVU: busy=%0b result=0x%08h", busy, result);
    run_op(C_MUL, 32'd6, 32'd7, lat, bsy, res);
    check("post_flush_mul", res, 32'd42);
    check("post_flush_latency", lat, 32'd2);
    $display("[TB] MUL after flush: result=0x%08h lat=%0d", res, lat);
    @(posedge clk); #1;

    // Reset during MUL
    start = 1'b1; alu_ctrl = C_MUL; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("rstmul_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmul_busy", {31'd0, busy}, 32'd0);
    check("rstmul_done", {31'd0, done}, 32'd0);
    check("rstmul_result", result, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    check("rstmul_no_done", seen_done, 32'd0);
    $display("[TB] reset during MUL: busy=%0b done=%0b result=0x%08h", busy, done, result);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
